// File: rtl/data_mem.sv
// Byte-addressable data memory: combinational formatted loads, byte-lane stores,
// sticky fault capture and load/store counters. Optional macro: DMEM_MISALIGN_TRAP_EN.
module data_mem #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  funct3,
  input  logic        MemRD,
  input  logic        MemWR,
  output logic [31:0] dataR,
  output logic        fault,
  output logic        err_sticky,
  output logic [31:0] fault_addr,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [31:0] mem [DEPTH];

  logic [ADDR_BITS-1:0] word_idx;
  logic [31:0]          rd_word;
  logic [7:0]           rd_byte;
  logic [15:0]          rd_half;
  logic                 out_of_range;
  logic                 illegal_f3;
  logic                 misaligned;
  logic [3:0]           byte_en;
  logic [31:0]          wr_data;
  logic                 wr_en;

  logic        err_sticky_q, err_sticky_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [31:0] load_cnt_q,   load_cnt_d;
  logic [31:0] store_cnt_q,  store_cnt_d;

  always_comb begin
    word_idx     = addr[ADDR_BITS+1:2];
    out_of_range = |addr[31:ADDR_BITS+2];
    rd_word      = mem[word_idx];
    rd_byte      = rd_word[{addr[1:0], 3'b000} +: 8];
    rd_half      = addr[1] ? rd_word[31:16] : rd_word[15:0];

    illegal_f3 = 1'b0;
    if (MemRD && (funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111))
      illegal_f3 = 1'b1;
    if (MemWR && (funct3 > 3'b010))
      illegal_f3 = 1'b1;

`ifdef DMEM_MISALIGN_TRAP_EN
    misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                 ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`else
    // Sub-word lanes are aligned down, so misalignment is harmless here.
    misaligned = 1'b0;
`endif

    fault = (MemRD || MemWR) &&
            (out_of_range || illegal_f3 || (MemRD && MemWR) || misaligned);

    dataR = 32'h0;
    if (MemRD && !fault) begin
      unique case (funct3)
        3'b000:  dataR = {{24{rd_byte[7]}}, rd_byte};
        3'b001:  dataR = {{16{rd_half[15]}}, rd_half};
        3'b010:  dataR = rd_word;
        3'b100:  dataR = {24'h0, rd_byte};
        3'b101:  dataR = {16'h0, rd_half};
        default: dataR = 32'h0;
      endcase
    end

    byte_en = 4'b0000;
    wr_data = wdata;
    unique case (funct3[1:0])
      2'b00: begin
        byte_en = 4'b0001 << addr[1:0];
        wr_data = {4{wdata[7:0]}};
      end
      2'b01: begin
        byte_en = addr[1] ? 4'b1100 : 4'b0011;
        wr_data = {2{wdata[15:0]}};
      end
      2'b10:   byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase

    // Reset in the same cycle drops the store.
    wr_en = MemWR && !fault && !rst;
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (wr_en && byte_en[b])
        mem[word_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
  end

  always_comb begin
    err_sticky_d = err_sticky_q;
    fault_addr_d = fault_addr_q;
    load_cnt_d   = load_cnt_q;
    store_cnt_d  = store_cnt_q;
    if (fault && !err_sticky_q) begin
      err_sticky_d = 1'b1;
      fault_addr_d = addr;
    end
    if (MemRD && !fault)
      load_cnt_d = load_cnt_q + 32'd1;
    if (MemWR && !fault)
      store_cnt_d = store_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_sticky_q <= 1'b0;
      fault_addr_q <= 32'h0;
      load_cnt_q   <= 32'h0;
      store_cnt_q  <= 32'h0;
    end else begin
      err_sticky_q <= err_sticky_d;
      fault_addr_q <= fault_addr_d;
      load_cnt_q   <= load_cnt_d;
      store_cnt_q  <= store_cnt_d;
    end
  end

  assign err_sticky = err_sticky_q;
  assign fault_addr = fault_addr_q;
  assign load_cnt   = load_cnt_q;
  assign store_cnt  = store_cnt_q;

endmodule

// File: tb/tb_data_mem.sv
// Directed self-checking bench for data_mem; expected values are hand-computed.
module tb_data_mem;

  logic        clk;
  logic        rst;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0]  funct3;
  logic        MemRD;
  logic        MemWR;
  logic [31:0] dataR;
  logic        fault;
  logic        err_sticky;
  logic [31:0] fault_addr;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;

  int total = 0;
  int bad   = 0;

  data_mem #(.ADDR_BITS(10)) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .wdata      (wdata),
    .funct3     (funct3),
    .MemRD      (MemRD),
    .MemWR      (MemWR),
    .dataR      (dataR),
    .fault      (fault),
    .err_sticky (err_sticky),
    .fault_addr (fault_addr),
    .load_cnt   (load_cnt),
    .store_cnt  (store_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one access just after a rising edge; return at the falling edge for sampling.
  task automatic go(input logic r, input logic rd, input logic wr, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wd);
    @(posedge clk);
    #1;
    rst = r; MemRD = rd; MemWR = wr; funct3 = f3; addr = a; wdata = wd;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; MemRD = 1'b0; MemWR = 1'b0; funct3 = 3'b000; addr = 32'h0; wdata = 32'h0;
    repeat (2) @(posedge clk);
    go(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("rst_sticky", {31'h0, err_sticky}, 32'h0);
    chk("rst_faddr", fault_addr, 32'h0);
    chk("rst_ldcnt", load_cnt, 32'h0);
    chk("rst_stcnt", store_cnt, 32'h0);

    go(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h8000_00F1);
    chk("sw_nofault", {31'h0, fault}, 32'h0);
    chk("sw_dataR_idle", dataR, 32'h0);
    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("lw_10", dataR, 32'h8000_00F1);
    chk("stcnt_1", store_cnt, 32'd1);
    chk("ldcnt_0", load_cnt, 32'd0);
    go(1'b0, 1'b1, 1'b0, 3'b000, 32'h10, 32'h0);
    chk("lb_10", dataR, 32'hFFFF_FFF1);
    chk("ldcnt_1", load_cnt, 32'd1);
    go(1'b0, 1'b1, 1'b0, 3'b100, 32'h10, 32'h0);
    chk("lbu_10", dataR, 32'h0000_00F1);
    go(1'b0, 1'b1, 1'b0, 3'b001, 32'h12, 32'h0);
    chk("lh_12", dataR, 32'hFFFF_8000);
    go(1'b0, 1'b1, 1'b0, 3'b101, 32'h12, 32'h0);
    chk("lhu_12", dataR, 32'h0000_8000);

    go(1'b0, 1'b0, 1'b1, 3'b010, 32'h10, 32'h1122_3344);
    go(1'b0, 1'b0, 1'b1, 3'b000, 32'h13, 32'h0000_00AB);
    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("sb_lane3", dataR, 32'hAB22_3344);
    chk("stcnt_3", store_cnt, 32'd3);

    go(1'b0, 1'b0, 1'b1, 3'b010, 32'h0, 32'h0);
    go(1'b0, 1'b0, 1'b1, 3'b010, 32'h1000, 32'hFFFF_FFFF);
    chk("oor_fault", {31'h0, fault}, 32'h1);
    chk("oor_sticky_pre", {31'h0, err_sticky}, 32'h0);
    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h0, 32'h0);
    chk("oor_no_alias_wr", dataR, 32'h0);
    chk("oor_sticky", {31'h0, err_sticky}, 32'h1);
    chk("oor_faddr", fault_addr, 32'h1000);
    chk("oor_stcnt", store_cnt, 32'd4);
    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h2000, 32'h0);
    chk("oor2_fault", {31'h0, fault}, 32'h1);
    chk("oor2_dataR", dataR, 32'h0);
    go(1'b0, 1'b1, 1'b0, 3'b011, 32'h10, 32'h0);
    chk("ill_ld_fault", {31'h0, fault}, 32'h1);
    chk("ill_ld_dataR", dataR, 32'h0);
    chk("faddr_kept", fault_addr, 32'h1000);
    go(1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h0000_DEAD);
    chk("both_fault", {31'h0, fault}, 32'h1);
    chk("both_dataR", dataR, 32'h0);
    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("both_no_write", dataR, 32'hAB22_3344);
    chk("ldcnt_7", load_cnt, 32'd7);

    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h12, 32'h0);
`ifdef DMEM_MISALIGN_TRAP_EN
    chk("mis_lw_fault", {31'h0, fault}, 32'h1);
    chk("mis_lw_dataR", dataR, 32'h0);
    go(1'b0, 1'b0, 1'b1, 3'b010, 32'h14, 32'h0);
    chk("mis_ldcnt", load_cnt, 32'd8);
`else
    chk("mis_lw_fault", {31'h0, fault}, 32'h0);
    chk("mis_lw_dataR", dataR, 32'hAB22_3344);
    go(1'b0, 1'b0, 1'b1, 3'b010, 32'h14, 32'h0);
    chk("mis_ldcnt", load_cnt, 32'd9);
`endif
    go(1'b0, 1'b0, 1'b1, 3'b001, 32'h16, 32'h0000_BEEF);
    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h14, 32'h0);
    chk("sh_upper", dataR, 32'hBEEF_0000);

    go(1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h0);
    go(1'b0, 1'b0, 1'b1, 3'b010, 32'h20, 32'h5);
    chk("st_cycle_dataR", dataR, 32'h0);
    chk("st_cycle_nofault", {31'h0, fault}, 32'h0);
    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    chk("ld_next_cycle", dataR, 32'h5);
    chk("stcnt_8", store_cnt, 32'd8);

    go(1'b1, 1'b0, 1'b1, 3'b010, 32'h20, 32'h7);
    go(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("mid_rst_ldcnt", load_cnt, 32'h0);
    chk("mid_rst_stcnt", store_cnt, 32'h0);
    chk("mid_rst_sticky", {31'h0, err_sticky}, 32'h0);
    chk("mid_rst_faddr", fault_addr, 32'h0);
    go(1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
    chk("rst_drops_store", dataR, 32'h5);
    go(1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("post_rst_ldcnt", load_cnt, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
